store_commit: RTL and testbench
===============================

# store_commit

Back end of the retire stage's store path. It receives each store that retires in program order, holds it in a small in-order FIFO, and drains it to the data-memory write port over a req/ack handshake. Stores that cross an 8-byte boundary are split into two aligned beats. It asserts `retire_stall` toward the retire stage whenever it cannot accept another store.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `store_valid`  in  1  a store retires this cycle. Driven by retire's `lsq_decrement`.
- `store_addr`  in  64  byte address, taken from the retired LSQ entry.
- `store_data`  in  64  store data, right-justified.
- `store_size`  in  4  byte count, driven by retire's `le_size`. Legal values are 0, 1, 2, 4 and 8.
- `retire_stall`  out  1  FIFO full; retire must not retire.
- `mem_req`  out  1  write beat valid.
- `mem_addr`  out  64  8-byte-aligned beat address; bits [2:0] are always 0.
- `mem_wdata`  out  64  lane-positioned write data.
- `mem_wstrb`  out  8  byte-lane enables.
- `mem_ack`  in  1  memory accepts the current beat.
- `empty`  out  1  FIFO empty and FSM idle. Used for fences and flushes.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err`  out  1  sticky error flag.

## Operation
Enqueue:
- A store is written at the tail when `store_valid` is high, `store_size` is nonzero, and `count < DEPTH`.
- `store_size` = 0 is ignored silently.
- `store_size` of 3, 5, 6, 7 or above 8 is dropped and sets `err`.
- `store_valid` while full is dropped and sets `err`. Retire's stall contract makes this a protocol violation.
- `err` is cleared only by reset.

Drain FSM, states IDLE, BEAT0, BEAT1:
- IDLE: if the FIFO is non-empty, latch the head entry and compute the beat data:
  - `off` = `addr[2:0]`.
  - `sh_data[127:0]` = `data << (8*off)`.
  - `sh_strb[15:0]` = `((1<<size)-1) << off`.
  - Then go to BEAT0.
- BEAT0:
  - Drive `mem_req`=1, `mem_addr` = `{addr[63:3],3'b0}`, `mem_wdata` = `sh_data[63:0]`, `mem_wstrb` = `sh_strb[7:0]`.
  - On `mem_ack`: if `sh_strb[15:8]` is nonzero, go to BEAT1. Otherwise pop the head and go to IDLE.
- BEAT1:
  - Drive `mem_req`=1, `mem_addr` = beat-0 address + 8 (64-bit wrap permitted), `mem_wdata` = `sh_data[127:64]`, `mem_wstrb` = `sh_strb[15:8]`.
  - On `mem_ack`, pop the head and go to IDLE.
- Stores drain strictly in enqueue order, and beats of one store are never interleaved with another.

FIFO and status:
- Head and tail pointers wrap modulo DEPTH. `count` tracks occupancy.
- An enqueue and a pop in the same cycle leave `count` unchanged and both take effect.
- `retire_stall` = (`count` == DEPTH), decoded from the registered `count`.
- `empty` = (`count` == 0) && IDLE.

## Timing
Reset (asynchronous, active-low) forces:
- state IDLE, pointers 0, `count` 0, `err` 0.
- `mem_req`, `mem_addr`, `mem_wdata` and `mem_wstrb` 0; `retire_stall` 0; `empty` 1.
- Assertion mid-transaction abandons the beat immediately: `mem_req` falls without waiting for a clock, and all FIFO contents are discarded.

Latency and handshake:
- Memory outputs are registered.
- Store presented in cycle N: FIFO write at edge N→N+1. IDLE sees it in N+1 and `mem_req` rises in N+2.
- `mem_req` holds with `mem_addr`, `mem_wdata` and `mem_wstrb` stable until the cycle `mem_ack` is sampled high. `mem_ack` while `mem_req`=0 is ignored.
- An ack on BEAT0 of a split store drives BEAT1 in the next cycle; there is no bubble between the two beats.
- An ack on the final beat returns the FSM to IDLE. The next store's `mem_req` then rises 2 cycles after that ack, giving one idle bubble between stores.

Stall path:
- There is no combinational path from `mem_ack` or `store_valid` to `retire_stall`.
- When a pop frees a slot from full, `retire_stall` falls in the cycle after the pop edge.

## Test plan
- **Aligned SD**: SD to 0x1000, data 0x1122334455667788, ack immediate.
  - Required: one beat 2 cycles later, `mem_addr` 0x1000, `mem_wstrb` 0xFF, `mem_wdata` 0x1122334455667788, then `empty`=1.
- **Unaligned SH**: SH to 0x1003, data 0xABCD.
  - Required: `mem_addr` 0x1000, `mem_wstrb` 0x18, `mem_wdata[31:24]` 0xCD, `mem_wdata[39:32]` 0xAB.
- **Split SW**: SW to 0x1006, data 0xDEADBEEF.
  - Required beat 0: `mem_addr` 0x1000, `mem_wstrb` 0xC0, `mem_wdata[63:48]` 0xBEEF.
  - Required beat 1: `mem_addr` 0x1008, `mem_wstrb` 0x03, `mem_wdata[15:0]` 0xDEAD, issued on consecutive cycles after the beat-0 ack.
- **Fill and overflow**: `mem_ack` held 0, four stores enqueued, then a fifth `store_valid`.
  - Required: `retire_stall`=1 after the fourth, `count` stays 4, `err`=1.
  - Then release `mem_ack`: the four stores drain in order and `retire_stall` falls the cycle after the first pop.
- **Back-pressure**: delay `mem_ack` by 3 cycles.
  - Required: `mem_req` and all beat fields stay stable for 4 cycles. A simultaneous enqueue during the pop leaves `count` unchanged.
- **Reset mid-transfer**: assert reset during BEAT1.
  - Required: `mem_req` falls without waiting for a clock, `count` 0, `empty` 1, `err` 0. After release, no beat issues until a new store arrives.

Source files
------------

// File: rtl/store_commit.sv
// Retire-stage store back end: in-order store FIFO drained to the data-memory
// write port as one or two 8-byte-aligned beats over a req/ack handshake.
module store_commit #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     store_valid,
    input  logic [63:0]              store_addr,
    input  logic [63:0]              store_data,
    input  logic [3:0]               store_size,
    output logic                     retire_stall,
    output logic                     mem_req,
    output logic [63:0]              mem_addr,
    output logic [63:0]              mem_wdata,
    output logic [7:0]               mem_wstrb,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    // Handshake: a beat is transferred on a rising clk edge where mem_req and
    // mem_ack are both high; mem_req and all beat fields hold until then.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          mem_req_q, mem_req_d;
    logic [63:0]   mem_addr_q, mem_addr_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]    mem_wstrb_q, mem_wstrb_d;
    logic [63:0]   hi_data_q, hi_data_d;
    logic [7:0]    hi_strb_q, hi_strb_d;

    logic [63:0]   fifo_addr_q [DEPTH];
    logic [63:0]   fifo_data_q [DEPTH];
    logic [3:0]    fifo_size_q [DEPTH];

    logic          full;
    logic          size_legal;
    logic          enq;
    logic          pop;
    logic [63:0]   head_addr;
    logic [2:0]    head_off;
    logic [7:0]    head_mask;
    logic [127:0]  head_sh_data;
    logic [15:0]   head_sh_strb;

    assign full = (count_q == FULL_CNT);

    always_comb begin
        size_legal = (store_size == 4'd1) || (store_size == 4'd2) ||
                     (store_size == 4'd4) || (store_size == 4'd8);
        enq   = store_valid && size_legal && !full;
        err_d = err_q;
        // Size 0 is a no-op store and never flags an error, even when full.
        if (store_valid && (store_size != 4'd0) && (!size_legal || full)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        head_addr = fifo_addr_q[head_q];
        head_off  = head_addr[2:0];
        case (fifo_size_q[head_q])
            4'd1:    head_mask = 8'h01;
            4'd2:    head_mask = 8'h03;
            4'd4:    head_mask = 8'h0F;
            4'd8:    head_mask = 8'hFF;
            default: head_mask = 8'h00;
        endcase
        head_sh_data = {64'b0, fifo_data_q[head_q]} << {head_off, 3'b000};
        head_sh_strb = {8'b0, head_mask} << head_off;
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        hi_data_d   = hi_data_q;
        hi_strb_d   = hi_strb_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = BEAT0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {head_addr[63:3], 3'b000};
                    mem_wdata_d = head_sh_data[63:0];
                    mem_wstrb_d = head_sh_strb[7:0];
                    hi_data_d   = head_sh_data[127:64];
                    hi_strb_d   = head_sh_strb[15:8];
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    if (hi_strb_q != 8'h00) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + 64'd8;
                        mem_wdata_d = hi_data_q;
                        mem_wstrb_d = hi_strb_q;
                    end else begin
                        pop         = 1'b1;
                        state_d     = IDLE;
                        mem_req_d   = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    pop         = 1'b1;
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        head_d  = pop ? head_q + AW'(1) : head_q;
        tail_d  = enq ? tail_q + AW'(1) : tail_q;
        count_d = count_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            hi_data_q   <= '0;
            hi_strb_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            hi_data_q   <= hi_data_d;
            hi_strb_q   <= hi_strb_d;
        end
    end

    // Entry storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[tail_q] <= store_addr;
            fifo_data_q[tail_q] <= store_data;
            fifo_size_q[tail_q] <= store_size;
        end
    end

    assign retire_stall = full;
    assign empty        = (count_q == '0) && (state_q == IDLE);
    assign count        = count_q;
    assign err          = err_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;

endmodule

// File: tb/tb_store_commit.sv
// Self-checking bench for store_commit: byte-wise beat model feeding an
// expected-beat queue, one task per scenario.
module tb_store_commit;

    logic        clk;
    logic        reset;
    logic        store_valid;
    logic [63:0] store_addr;
    logic [63:0] store_data;
    logic [3:0]  store_size;
    logic        retire_stall;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    logic [135:0] exp_q[$];

    store_commit #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .store_valid(store_valid), .store_addr(store_addr),
        .store_data(store_data), .store_size(store_size),
        .retire_stall(retire_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .empty(empty), .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    // Byte-wise placement model: byte j of the data lands at position off+j.
    function automatic void model(input logic [63:0] a, input logic [63:0] d,
                                  input logic [3:0] sz, output logic [135:0] b0,
                                  output logic [135:0] b1, output bit two);
        logic [63:0] w0, w1;
        logic [7:0]  s0, s1;
        logic [60:0] hi_a;
        int p;
        w0 = '0; w1 = '0; s0 = '0; s1 = '0;
        for (int j = 0; j < 8; j++) begin
            p = int'(a[2:0]) + j;
            if (p < 8) begin
                w0[p*8 +: 8] = d[j*8 +: 8];
                if (j < int'(sz)) s0[p] = 1'b1;
            end else begin
                w1[(p-8)*8 +: 8] = d[j*8 +: 8];
                if (j < int'(sz)) s1[p-8] = 1'b1;
            end
        end
        hi_a = a[63:3] + 61'd1;
        b0 = {a[63:3], 3'b000, w0, s0};
        b1 = {hi_a, 3'b000, w1, s1};
        two = (s1 != 8'h00);
    endfunction

    // Holds a store on the inputs for one cycle; call and return at posedge+1.
    task automatic drive_store(input logic [63:0] a, input logic [63:0] d,
                               input logic [3:0] sz, input bit accepted);
        logic [135:0] b0, b1;
        bit two;
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
        store_size  = sz;
        if (accepted) begin
            model(a, d, sz, b0, b1, two);
            exp_q.push_back(b0);
            if (two) exp_q.push_back(b1);
        end
        @(posedge clk); #1;
        store_valid = 1'b0;
        store_size  = 4'd0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        int n = 0;
        while (!mem_req && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = mem_req;
    endtask

    task automatic ack_beat();
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    function automatic logic [3:0] rand_size();
        logic [3:0] tbl [4];
        tbl[0] = 4'd1; tbl[1] = 4'd2; tbl[2] = 4'd4; tbl[3] = 4'd8;
        return tbl[$urandom_range(0, 3)];
    endfunction

    task automatic test_reset();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %0b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 64'h0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 64'h0) begin n_err++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        n_cmp++; if (mem_wstrb !== 8'h0) begin n_err++; $display("FAIL rst_mem_wstrb got %h want 0", mem_wstrb); end
        n_cmp++; if (retire_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0b want 0", retire_stall); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %0b want 1", empty); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %0b want 0", err); end
    endtask

    task automatic test_aligned_sd();
        logic [135:0] e;
        mem_ack = 1'b1;
        drive_store(64'h1000, 64'h1122334455667788, 4'd8, 1'b1);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sd_latency_early got %0b want 0", mem_req); end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sd_req got %0b want 1", mem_req); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL sd_beat got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
        n_cmp++; if (mem_addr !== 64'h1000 || mem_wstrb !== 8'hFF || mem_wdata !== 64'h1122334455667788) begin
            n_err++; $display("FAIL sd_fields got %h/%h/%h want 1000/ff/1122334455667788", mem_addr, mem_wstrb, mem_wdata); end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sd_req_drop got %0b want 0", mem_req); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL sd_empty got %0b want 1", empty); end
    endtask

    task automatic test_unaligned_sh();
        logic [135:0] e;
        bit ok;
        drive_store(64'h1003, 64'hABCD, 4'd2, 1'b1);
        wait_req(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sh_timeout got no mem_req want mem_req"); end
        e = exp_q.pop_front();
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL sh_beat got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
        n_cmp++; if (mem_addr !== 64'h1000 || mem_wstrb !== 8'h18 || mem_wdata[39:24] !== 16'hABCD) begin
            n_err++; $display("FAIL sh_fields got %h/%h/%h want 1000/18/abcd", mem_addr, mem_wstrb, mem_wdata[39:24]); end
        ack_beat();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL sh_req_drop got %0b want 0", mem_req); end
    endtask

    task automatic test_split_sw();
        logic [135:0] e;
        bit ok;
        drive_store(64'h1006, 64'hDEADBEEF, 4'd4, 1'b1);
        wait_req(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sw_timeout got no mem_req want mem_req"); end
        e = exp_q.pop_front();
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL sw_beat0 got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
        n_cmp++; if (mem_addr !== 64'h1000 || mem_wstrb !== 8'hC0 || mem_wdata[63:48] !== 16'hBEEF) begin
            n_err++; $display("FAIL sw_b0_fields got %h/%h/%h want 1000/c0/beef", mem_addr, mem_wstrb, mem_wdata[63:48]); end
        ack_beat();
        e = exp_q.pop_front();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sw_no_bubble got %0b want 1", mem_req); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL sw_beat1 got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
        n_cmp++; if (mem_addr !== 64'h1008 || mem_wstrb !== 8'h03 || mem_wdata[15:0] !== 16'hDEAD) begin
            n_err++; $display("FAIL sw_b1_fields got %h/%h/%h want 1008/03/dead", mem_addr, mem_wstrb, mem_wdata[15:0]); end
        ack_beat();
        n_cmp++; if (mem_req !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL sw_done got req=%0b empty=%0b want 0/1", mem_req, empty); end
    endtask

    task automatic test_fill_overflow();
        logic [135:0] e;
        bit ok;
        int guard;
        mem_ack = 1'b0;
        drive_store(64'h3000, {$urandom, $urandom}, 4'd8, 1'b1);
        for (int i = 0; i < 3; i++) drive_store({$urandom, $urandom}, {$urandom, $urandom}, rand_size(), 1'b1);
        n_cmp++; if (retire_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall got %0b want 1", retire_stall); end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
        drive_store({$urandom, $urandom}, {$urandom, $urandom}, 4'd8, 1'b0);
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", count); end
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ovf_err got %0b want 1", err); end
        wait_req(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL fill_timeout got no mem_req want mem_req"); end
        e = exp_q.pop_front();
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL fill_beat_first got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (retire_stall !== 1'b0) begin n_err++; $display("FAIL stall_fall got %0b want 0", retire_stall); end
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pop_count got %0d want 3", count); end
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            if (mem_req) begin
                e = exp_q.pop_front();
                n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL fill_drain got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
            end
            @(posedge clk); #1;
            guard++;
        end
        mem_ack = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fill_drain_timeout got %0d beats left want 0", exp_q.size()); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty got %0b want 1", empty); end
    endtask

    task automatic test_back_pressure();
        logic [135:0] e;
        logic [135:0] b0, b1;
        bit ok, two;
        logic [63:0] a2, d2;
        mem_ack = 1'b0;
        drive_store(64'h2004, {$urandom, $urandom}, 4'd4, 1'b1);
        wait_req(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout got no mem_req want mem_req"); end
        e = exp_q.pop_front();
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL bp_count_pre got %0d want 1", count); end
        a2 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem_req !== 1'b1 || {mem_addr, mem_wdata, mem_wstrb} !== e) begin
                n_err++; $display("FAIL bp_hold cycle %0d got req=%0b %h want req=1 %h", i, mem_req, {mem_addr, mem_wdata, mem_wstrb}, e);
            end
            if (i == 3) begin
                mem_ack     = 1'b1;
                store_valid = 1'b1;
                store_addr  = a2;
                store_data  = d2;
                store_size  = 4'd2;
                model(a2, d2, 4'd2, b0, b1, two);
                exp_q.push_back(b0);
                if (two) exp_q.push_back(b1);
            end
            @(posedge clk); #1;
        end
        mem_ack     = 1'b0;
        store_valid = 1'b0;
        store_size  = 4'd0;
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL bp_count_same got %0d want 1", count); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL bp_bubble got %0b want 0", mem_req); end
        while (exp_q.size() != 0) begin
            wait_req(20, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL bp2_timeout got no mem_req want mem_req"); exp_q.delete(); end
            else begin
                e = exp_q.pop_front();
                n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL bp2_beat got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
                ack_beat();
            end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL bp_empty got %0b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        logic [135:0] e;
        bit ok;
        int seen;
        mem_ack = 1'b0;
        drive_store(64'h40FD, 64'h0102030405060708, 4'd8, 1'b1);
        drive_store(64'h5000, 64'h55, 4'd1, 1'b1);
        wait_req(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_timeout got no mem_req want mem_req"); end
        ack_beat();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 64'h4100) begin n_err++; $display("FAIL rm_in_beat1 got req=%0b addr=%h want 1/4100", mem_req, mem_addr); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rm_req_async got %0b want 0", mem_req); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rm_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rm_empty got %0b want 1", empty); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rm_err got %0b want 0", err); end
        n_cmp++; if (mem_addr !== 64'h0 || mem_wstrb !== 8'h0) begin n_err++; $display("FAIL rm_fields got %h/%h want 0/0", mem_addr, mem_wstrb); end
        exp_q.delete();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mem_req) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rm_no_beat got %0d req cycles want 0", seen); end
        drive_store(64'h6001, 64'h77, 4'd1, 1'b1);
        wait_req(20, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_new_timeout got no mem_req want mem_req"); end
        e = exp_q.pop_front();
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin n_err++; $display("FAIL rm_new_beat got %h want %h", {mem_addr, mem_wdata, mem_wstrb}, e); end
        ack_beat();
    endtask

    task automatic test_size_filter();
        drive_store(64'h7000, 64'h1, 4'd0, 1'b0);
        n_cmp++; if (err !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL size0 got err=%0b count=%0d want 0/0", err, count); end
        drive_store(64'h7000, 64'h1, 4'd3, 1'b0);
        n_cmp++; if (err !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL size3 got err=%0b count=%0d want 1/0", err, count); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mem_req !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL size_nobeat got req=%0b empty=%0b want 0/1", mem_req, empty); end
    endtask

    initial begin
        reset       = 1'b0;
        store_valid = 1'b0;
        store_addr  = '0;
        store_data  = '0;
        store_size  = '0;
        mem_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        test_reset();
        test_aligned_sd();
        test_unaligned_sh();
        test_split_sw();
        test_fill_overflow();
        test_back_pressure();
        test_reset_mid();
        test_size_filter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
